// File: rtl/fetch_stage_if.sv
// ----------------------------------------------------------------------------
// fetch_stage_if
//   Instruction-memory read port shared by the fetch stage and imem.
//
//   Handshake: the master raises req with addr and holds both unchanged
//   until the slave answers with ack for exactly one cycle; rdata is valid
//   only in that ack cycle. ack may come in the very first req cycle.
//   A request is retired on the cycle req && ack. The slave never sees addr
//   change while req is high.
//
//   Signals
//     req    master->slave  read request
//     addr   master->slave  byte address of the word to read
//     ack    slave->master  read complete this cycle
//     rdata  slave->master  instruction word, valid with ack
// ----------------------------------------------------------------------------
interface fetch_stage_if;
    logic        req;
    logic [31:0] addr;
    logic        ack;
    logic [31:0] rdata;

    modport master (output req, output addr, input ack, input rdata);
    modport slave  (input req, input addr, output ack, output rdata);
endinterface

// File: rtl/fetch_stage.sv
// ----------------------------------------------------------------------------
// fetch_stage
//   Instruction fetch stage: owns the PC, reads instruction memory through
//   the imem port and presents one instruction slot to the F/D register,
//   which loads when fetch_valid && !stall. A one-entry pending buffer
//   absorbs a word that returns while the slot is occupied and stalled.
//   redirect flushes the slot and pending buffer and restarts at redirect_pc.
//
//   Ports
//     clk, rst          clock; synchronous active-high reset
//     stall             F/D register cannot accept this cycle
//     redirect          flush and restart fetch at redirect_pc
//     redirect_pc       redirect target (bits [1:0] ignored)
//     imem              instruction memory read port (master side)
//     pc_value_next     PC of the instruction in the output slot
//     next_instruction  instruction in the output slot (NOP_INSTR if empty)
//     fetch_valid       output slot holds a valid instruction
//     dbg_state         current FSM state (FETCH=0, FULL=1, DRAIN=2)
// ----------------------------------------------------------------------------
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                stall,
    input  logic                redirect,
    input  logic [31:0]         redirect_pc,
    fetch_stage_if.master       imem,
    output logic [31:0]         pc_value_next,
    output logic [31:0]         next_instruction,
    output logic                fetch_valid,
    output logic [1:0]          dbg_state
);

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,   // request outstanding at pc
        S_FULL  = 2'd1,   // slot and pending both occupied, no request
        S_DRAIN = 2'd2    // wrong-path request still outstanding, data dropped
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;             // address of the next word to fetch
    logic [31:0] addr_q, addr_d;         // address presented on imem.addr
    logic [31:0] slot_pc_q, slot_pc_d;
    logic [31:0] slot_instr_q, slot_instr_d;
    logic        slot_valid_q, slot_valid_d;
    logic [31:0] pend_pc_q, pend_pc_d;
    logic [31:0] pend_instr_q, pend_instr_d;

    logic        consume;
    logic [31:0] pc_plus4;
    logic [31:0] redirect_tgt;

    assign consume      = slot_valid_q && !stall;
    assign pc_plus4     = pc_q + 32'd4;
    assign redirect_tgt = {redirect_pc[31:2], 2'b00};

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        addr_d       = addr_q;
        slot_pc_d    = slot_pc_q;
        slot_instr_d = slot_instr_q;
        slot_valid_d = slot_valid_q;
        pend_pc_d    = pend_pc_q;
        pend_instr_d = pend_instr_q;

        if (redirect) begin
            slot_valid_d = 1'b0;
            slot_instr_d = NOP_INSTR;
            pend_pc_d    = 32'd0;
            pend_instr_d = NOP_INSTR;
            pc_d         = redirect_tgt;
            case (state_q)
                S_FETCH, S_DRAIN: begin
                    // A request that is still open must complete at its old
                    // address before the new target can be issued.
                    if (imem.ack) begin
                        state_d = S_FETCH;
                        addr_d  = redirect_tgt;
                    end else begin
                        state_d = S_DRAIN;
                    end
                end
                default: begin
                    state_d = S_FETCH;
                    addr_d  = redirect_tgt;
                end
            endcase
        end else begin
            // Slot drains whenever the F/D register takes it; a refill on
            // the same edge below overrides this.
            if (consume) begin
                slot_valid_d = 1'b0;
                slot_instr_d = NOP_INSTR;
            end
            case (state_q)
                S_FETCH: begin
                    if (imem.ack) begin
                        pc_d   = pc_plus4;
                        addr_d = pc_plus4;
                        if (!slot_valid_q || consume) begin
                            slot_pc_d    = pc_q;
                            slot_instr_d = imem.rdata;
                            slot_valid_d = 1'b1;
                        end else begin
                            pend_pc_d    = pc_q;
                            pend_instr_d = imem.rdata;
                            state_d      = S_FULL;
                        end
                    end
                end
                S_FULL: begin
                    if (consume) begin
                        slot_pc_d    = pend_pc_q;
                        slot_instr_d = pend_instr_q;
                        slot_valid_d = 1'b1;
                        pend_pc_d    = 32'd0;
                        pend_instr_d = NOP_INSTR;
                        addr_d       = pc_q;
                        state_d      = S_FETCH;
                    end
                end
                S_DRAIN: begin
                    if (imem.ack) begin
                        addr_d  = pc_q;
                        state_d = S_FETCH;
                    end
                end
                default: begin
                    state_d = S_FETCH;
                    addr_d  = pc_q;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_FETCH;
            pc_q         <= RESET_PC;
            addr_q       <= RESET_PC;
            slot_pc_q    <= 32'd0;
            slot_instr_q <= NOP_INSTR;
            slot_valid_q <= 1'b0;
            pend_pc_q    <= 32'd0;
            pend_instr_q <= NOP_INSTR;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            addr_q       <= addr_d;
            slot_pc_q    <= slot_pc_d;
            slot_instr_q <= slot_instr_d;
            slot_valid_q <= slot_valid_d;
            pend_pc_q    <= pend_pc_d;
            pend_instr_q <= pend_instr_d;
        end
    end

    // Request is a pure decode of the registered state, so it never
    // depends on stall or any other same-cycle input.
    assign imem.req         = (state_q == S_FETCH) || (state_q == S_DRAIN);
    assign imem.addr        = addr_q;
    assign pc_value_next    = slot_pc_q;
    assign next_instruction = slot_instr_q;
    assign fetch_valid      = slot_valid_q;
    assign dbg_state        = state_q;

endmodule

// File: tb/tb_fetch_stage.sv
// ----------------------------------------------------------------------------
// tb_fetch_stage
//   Directed, table-driven bench for fetch_stage. Each record holds the
//   outputs expected before its inputs are applied and the inputs driven
//   for the following rising edge; imem ack/rdata come from the table.
// ----------------------------------------------------------------------------
module tb_fetch_stage;

    localparam logic [31:0] RST_PC = 32'h0000_0100;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    typedef struct {
        logic        stall;
        logic        redirect;
        logic [31:0] redirect_pc;
        logic        ack;
        logic [31:0] rdata;
        logic        exp_req;
        logic [31:0] exp_addr;   // checked only when exp_req
        logic        exp_valid;
        logic [31:0] exp_pc;     // checked only when exp_valid
        logic [31:0] exp_instr;
    } vec_t;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] pc_value_next;
    logic [31:0] next_instruction;
    logic        fetch_valid;
    logic [1:0]  dbg_state;

    fetch_stage_if imem ();

    fetch_stage #(.RESET_PC(RST_PC), .NOP_INSTR(NOP)) dut (
        .clk              (clk),
        .rst              (rst),
        .stall            (stall),
        .redirect         (redirect),
        .redirect_pc      (redirect_pc),
        .imem             (imem),
        .pc_value_next    (pc_value_next),
        .next_instruction (next_instruction),
        .fetch_valid      (fetch_valid),
        .dbg_state        (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    vec_t vecs[$];
    int   n_vec;
    int   n_bad;

    task automatic add_vec(input logic st, input logic rd, input logic [31:0] rpc,
                           input logic ak, input logic [31:0] dat,
                           input logic e_req, input logic [31:0] e_addr,
                           input logic e_v, input logic [31:0] e_pc,
                           input logic [31:0] e_ins);
        vec_t v;
        v.stall = st; v.redirect = rd; v.redirect_pc = rpc;
        v.ack = ak; v.rdata = dat;
        v.exp_req = e_req; v.exp_addr = e_addr;
        v.exp_valid = e_v; v.exp_pc = e_pc; v.exp_instr = e_ins;
        vecs.push_back(v);
    endtask

    // Compare current outputs (sampled at negedge) against expectations.
    task automatic check(input string name, input logic e_req, input logic [31:0] e_addr,
                         input logic e_v, input logic [31:0] e_pc,
                         input logic [31:0] e_ins);
        logic ok;
        ok = (imem.req === e_req) && (fetch_valid === e_v) &&
             (next_instruction === e_ins) &&
             (!e_req || imem.addr === e_addr) &&
             (!e_v || pc_value_next === e_pc);
        n_vec++;
        if (!ok) begin
            n_bad++;
            $display("FAIL %s: got req=%0b addr=%h valid=%0b pc=%h instr=%h, want req=%0b addr=%h valid=%0b pc=%h instr=%h",
                     name, imem.req, imem.addr, fetch_valid, pc_value_next, next_instruction,
                     e_req, e_addr, e_v, e_pc, e_ins);
        end
    endtask

    task automatic drive(input logic st, input logic rd, input logic [31:0] rpc,
                         input logic ak, input logic [31:0] dat);
        stall = st; redirect = rd; redirect_pc = rpc;
        imem.ack = ak; imem.rdata = dat;
    endtask

    initial begin
        n_vec = 0;
        n_bad = 0;
        rst = 1'b1;
        drive(1'b0, 1'b0, 32'd0, 1'b0, 32'd0);

        //      st rd rpc           ak dat            req addr          v  pc            instr
        // stream: one instruction per cycle, 1 cycle after each ack
        add_vec(0, 0, 32'h0,        1, 32'hAABBAABB,  1, 32'h100,       0, 32'h0,        NOP);
        add_vec(0, 0, 32'h0,        1, 32'hCCCCCCCC,  1, 32'h104,       1, 32'h100,      32'hAABBAABB);
        // back-pressure: word returning under stall goes to pending, req drops
        add_vec(1, 0, 32'h0,        0, 32'h0,         1, 32'h108,       1, 32'h104,      32'hCCCCCCCC);
        add_vec(1, 0, 32'h0,        1, 32'h11111111,  1, 32'h108,       1, 32'h104,      32'hCCCCCCCC);
        add_vec(1, 0, 32'h0,        0, 32'h0,         0, 32'h0,         1, 32'h104,      32'hCCCCCCCC);
        add_vec(0, 0, 32'h0,        0, 32'h0,         0, 32'h0,         1, 32'h104,      32'hCCCCCCCC);
        add_vec(0, 0, 32'h0,        0, 32'h0,         1, 32'h10C,       1, 32'h108,      32'h11111111);
        // stall with empty slot is ignored
        add_vec(1, 0, 32'h0,        0, 32'h0,         1, 32'h10C,       0, 32'h0,        NOP);
        add_vec(1, 0, 32'h0,        1, 32'h22222222,  1, 32'h10C,       0, 32'h0,        NOP);
        // redirect under stall with no ack -> drain old request
        add_vec(1, 1, 32'h200,      0, 32'h0,         1, 32'h110,       1, 32'h10C,      32'h22222222);
        add_vec(0, 0, 32'h0,        0, 32'h0,         1, 32'h110,       0, 32'h0,        NOP);
        add_vec(0, 0, 32'h0,        1, 32'h33333333,  1, 32'h110,       0, 32'h0,        NOP);
        // redirect with ack on same edge, unaligned target
        add_vec(0, 1, 32'h203,      1, 32'h44444444,  1, 32'h200,       0, 32'h0,        NOP);
        add_vec(0, 0, 32'h0,        1, 32'h55555555,  1, 32'h200,       0, 32'h0,        NOP);
        // go FULL then redirect from FULL to wrap address
        add_vec(1, 0, 32'h0,        1, 32'h66666666,  1, 32'h204,       1, 32'h200,      32'h55555555);
        add_vec(1, 1, 32'hFFFFFFFC, 0, 32'h0,         0, 32'h0,         1, 32'h200,      32'h55555555);
        add_vec(0, 0, 32'h0,        1, 32'hDEADBEEF,  1, 32'hFFFFFFFC,  0, 32'h0,        NOP);
        add_vec(0, 0, 32'h0,        0, 32'h0,         1, 32'h0,         1, 32'hFFFFFFFC, 32'hDEADBEEF);
        // redirect into DRAIN, then redirect again while draining
        add_vec(0, 1, 32'h300,      0, 32'h0,         1, 32'h0,         0, 32'h0,        NOP);
        add_vec(0, 1, 32'h400,      0, 32'h0,         1, 32'h0,         0, 32'h0,        NOP);
        add_vec(0, 0, 32'h0,        1, 32'h99999999,  1, 32'h0,         0, 32'h0,        NOP);
        add_vec(0, 0, 32'h0,        1, 32'h77777777,  1, 32'h400,       0, 32'h0,        NOP);
        add_vec(1, 0, 32'h0,        0, 32'h0,         1, 32'h404,       1, 32'h400,      32'h77777777);

        // reset held two cycles
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset", 1'b1, RST_PC, 1'b0, 32'h0, NOP);
        n_vec++;
        if (pc_value_next !== 32'h0 || dbg_state !== 2'd0) begin
            n_bad++;
            $display("FAIL reset_pc_state: got pc=%h state=%0d, want pc=0 state=0",
                     pc_value_next, dbg_state);
        end
        rst = 1'b0;

        foreach (vecs[i]) begin
            if (i != 0) @(negedge clk);
            check($sformatf("vec%0d", i), vecs[i].exp_req, vecs[i].exp_addr,
                  vecs[i].exp_valid, vecs[i].exp_pc, vecs[i].exp_instr);
            drive(vecs[i].stall, vecs[i].redirect, vecs[i].redirect_pc,
                  vecs[i].ack, vecs[i].rdata);
        end

        // rst mid-request: request at 0x404 outstanding, slot valid
        @(negedge clk);
        check("pre_rst", 1'b1, 32'h404, 1'b1, 32'h400, 32'h77777777);
        drive(1'b1, 1'b0, 32'h0, 1'b1, 32'hBBBBBBBB);
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst", 1'b1, RST_PC, 1'b0, 32'h0, NOP);
        rst = 1'b0;
        drive(1'b0, 1'b0, 32'h0, 1'b1, 32'hCAFEF00D);
        @(negedge clk);
        check("post_rst_fill", 1'b1, 32'h104, 1'b1, 32'h100, 32'hCAFEF00D);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
